// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus bundle for the sprite-DMA engine.
//   slave  : view taken by oam_dma_ctrl (CPU bus and mem_ctrl responses in,
//            mem_ctrl requests, CPU stall/read data and DMA status out).
//   master : view taken by the surrounding system (CPU core + mem_ctrl).
interface oam_dma_ctrl_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic [ADDR_W-1:0] cpu_addr_in;
  logic [DATA_W-1:0] cpu_data_in;
  logic              cpu_write_en;
  logic              cpu_read_en;
  logic [DATA_W-1:0] cpu_data_out;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_en;
  logic              mem_read_en;
  logic              mem_busy;
  logic              dma_active;
  logic              dma_done;

  modport slave (
    input  cpu_addr_in, cpu_data_in, cpu_write_en, cpu_read_en,
    input  mem_data_in, mem_busy,
    output cpu_data_out, cpu_stall,
    output mem_addr, mem_data_out, mem_write_en, mem_read_en,
    output dma_active, dma_done
  );

  modport master (
    output cpu_addr_in, cpu_data_in, cpu_write_en, cpu_read_en,
    output mem_data_in, mem_busy,
    input  cpu_data_out, cpu_stall,
    input  mem_addr, mem_data_out, mem_write_en, mem_read_en,
    input  dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine between the 6502 core and mem_ctrl's CPU port.
// In IDLE the CPU bus passes straight through. A CPU write to DMA_REG_ADDR
// stalls the CPU and copies page P ($PP00-$PPFF) into sprite RAM by
// alternating reads of {P,idx} with writes to OAM_DATA_ADDR.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - oam_dma_ctrl_if.slave: CPU bus in, cpu_data_out/cpu_stall out,
//          mem_ctrl request/response, dma_active / dma_done status
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic           clk,
  input  logic           rst,
  oam_dma_ctrl_if.slave  bus
);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ALIGN_W = 2;

  typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   page, page_nx;
  logic [DATA_W-1:0]   idx, idx_nx;
  logic [DATA_W-1:0]   byte_q, byte_nx;
  logic [ALIGN_W-1:0]  align_cnt, align_nx;
  logic                parity;
  logic                hold_q, hold_nx;
  logic                done_q, done_nx;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      page      <= '0;
      idx       <= '0;
      byte_q    <= '0;
      align_cnt <= '0;
      parity    <= 1'b0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      page      <= page_nx;
      idx       <= idx_nx;
      byte_q    <= byte_nx;
      align_cnt <= align_nx;
      parity    <= ~parity;
      hold_q    <= hold_nx;
      done_q    <= done_nx;
    end
  end

  // Next-state logic and mem_ctrl request drive
  always_comb begin
    state_nx         = state;
    page_nx          = page;
    idx_nx           = idx;
    byte_nx          = byte_q;
    align_nx         = align_cnt;
    hold_nx          = 1'b0;
    done_nx          = 1'b0;
    bus.mem_addr     = {page, idx};
    bus.mem_data_out = '0;
    bus.mem_write_en = 1'b0;
    bus.mem_read_en  = 1'b0;

    case (state)
      IDLE: begin
        bus.mem_addr     = bus.cpu_addr_in;
        bus.mem_data_out = bus.cpu_data_in;
        bus.mem_read_en  = bus.cpu_read_en;
        bus.mem_write_en = bus.cpu_write_en && (bus.cpu_addr_in != DMA_REG_ADDR);
        if (bus.cpu_write_en && (bus.cpu_addr_in == DMA_REG_ADDR)) begin
          page_nx  = bus.cpu_data_in;
          idx_nx   = '0;
          // Odd-cycle trigger waits one extra cycle to land on the read phase
          align_nx = parity ? ALIGN_W'(2) : ALIGN_W'(1);
          state_nx = ALIGN;
        end
      end
      ALIGN: begin
        if (align_cnt == ALIGN_W'(1)) state_nx = READ;
        else                          align_nx = align_cnt - ALIGN_W'(1);
      end
      READ: begin
        bus.mem_read_en = 1'b1;
        if (!bus.mem_busy) state_nx = WRITE;
      end
      WRITE: begin
        bus.mem_addr     = OAM_DATA_ADDR;
        bus.mem_write_en = 1'b1;
        // mem_data_in is only guaranteed on the first WRITE cycle; replay the
        // captured byte while mem_ctrl keeps us waiting.
        bus.mem_data_out = hold_q ? byte_q : bus.mem_data_in;
        if (!hold_q) byte_nx = bus.mem_data_in;
        if (bus.mem_busy) begin
          hold_nx = 1'b1;
        end else if (idx == 8'hFF) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          idx_nx   = idx + 8'd1;
          state_nx = READ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.cpu_data_out = bus.mem_data_in;
  assign bus.cpu_stall    = (state != IDLE);
  assign bus.dma_active   = (state != IDLE);
  assign bus.dma_done     = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: mem_ctrl/sprite-RAM model, bus monitor
// and directed plus randomized DMA runs.
module tb_oam_dma_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: pattern content unless a CPU passthrough write stored a byte
  logic [7:0] salt = 8'h00;
  logic [7:0] ram [65536];
  bit         written [65536];
  logic [7:0] spram [256];
  logic [7:0] oamaddr;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (written[a]) return ram[a];
    return 8'(a[7:0] ^ salt ^ (a[15:8] & salt));
  endfunction

  // Monitor state, written only by the monitor process
  logic       tb_par;
  logic       trig_par;
  int         edge_no = 0;
  int         stall_cnt = 0, done_cnt = 0, stretch = 0, zero_hit = 0;
  int         trig_edge = 0, first_rd_edge = -1;
  logic [7:0]  wr_log [$];
  logic [15:0] rd_log [$];

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      bus.mem_data_in <= 8'h00;
    end else begin
      if (bus.mem_read_en && !bus.mem_busy) bus.mem_data_in <= mem_val(bus.mem_addr);
      if (bus.mem_write_en && !bus.mem_busy) begin
        if (bus.mem_addr == 16'h2004) begin
          spram[oamaddr] = bus.mem_data_out;
          oamaddr = oamaddr + 8'd1;
          wr_log.push_back(bus.mem_data_out);
        end else if (bus.mem_addr == 16'h2003) begin
          oamaddr = bus.mem_data_out;
        end else begin
          ram[bus.mem_addr] = bus.mem_data_out;
          written[bus.mem_addr] = 1'b1;
        end
      end
      if (bus.dma_active && bus.mem_read_en && !bus.mem_busy) begin
        rd_log.push_back(bus.mem_addr);
        if (bus.mem_addr == 16'h0000) zero_hit++;
      end
      if (bus.dma_active && bus.mem_read_en && first_rd_edge < 0) first_rd_edge = edge_no;
      if (bus.dma_active && bus.mem_busy && (bus.mem_read_en || bus.mem_write_en)) stretch++;
      if (bus.cpu_stall) stall_cnt++;
      if (bus.dma_done) done_cnt++;
      if (!bus.cpu_stall && bus.cpu_write_en && bus.cpu_addr_in == 16'h4014) begin
        trig_edge     = edge_no;
        trig_par      = tb_par;
        first_rd_edge = -1;
      end
    end
    // Mirrors the free-running parity as seen during the coming cycle
    tb_par = rst ? 1'b0 : ~tb_par;
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr_in  = a;
    bus.cpu_data_in  = d;
    bus.cpu_write_en = 1'b1;
    @(negedge clk);
    bus.cpu_write_en = 1'b0;
  endtask

  // One full transfer. mode 0: no busy, 1: directed busy at idx 0x40/0x41, 2: random busy
  task automatic run_dma(input string tag, input logic [7:0] page, input logic want_par,
                         input int mode);
    int s0, d0, st0, w0, r0, z0, rb, wb, bad, n;
    logic got;
    int exp_stall;
    cpu_write(16'h2003, 8'h00);
    for (int k = 0; k < 4 && tb_par !== want_par; k++) @(negedge clk);
    s0 = stall_cnt; d0 = done_cnt; st0 = stretch; z0 = zero_hit;
    w0 = wr_log.size(); r0 = rd_log.size();
    rb = 0; wb = 0; got = 1'b0;
    bus.cpu_addr_in  = 16'h4014;
    bus.cpu_data_in  = page;
    bus.cpu_write_en = 1'b1;
    #1 check({tag, "_trig_not_fwd"}, 32'(bus.mem_write_en), 32'd0);
    @(negedge clk);
    bus.cpu_write_en = 1'b0;
    check({tag, "_trig_parity"}, 32'(trig_par), 32'(want_par));
    for (int c = 0; c < 3000 && !got; c++) begin
      bus.mem_busy = 1'b0;
      if (mode == 1) begin
        if (bus.mem_read_en && bus.mem_addr == {page, 8'h40} && rb < 3) begin
          bus.mem_busy = 1'b1; rb++;
        end else if (bus.mem_write_en && (wr_log.size() - w0) == 'h41 && wb < 2) begin
          bus.mem_busy = 1'b1; wb++;
        end
      end else if (mode == 2) begin
        bus.mem_busy = bus.dma_active && ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      if (bus.dma_done) got = 1'b1;
    end
    bus.mem_busy = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_stall_at_done"}, 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    // Lead-in cycles: 1 align cycle (even) or 2 (odd), then 512 read/write cycles
    exp_stall = (want_par ? 514 : 513) + (stretch - st0);
    if (mode == 1) exp_stall = 518;
    check({tag, "_stall_cycles"}, 32'(stall_cnt - s0), 32'(exp_stall));
    check({tag, "_first_read"}, 32'(first_rd_edge - trig_edge), want_par ? 32'd3 : 32'd2);
    n = wr_log.size() - w0;
    check({tag, "_write_count"}, 32'(n), 32'd256);
    bad = 0;
    for (int i = 0; i < 256 && i < n; i++)
      if (wr_log[w0 + i] !== mem_val({page, 8'(i)})) bad++;
    check({tag, "_write_data"}, 32'(bad), 32'd0);
    n = rd_log.size() - r0;
    bad = (n == 256) ? 0 : 1;
    for (int i = 0; i < 256 && i < n; i++)
      if (rd_log[r0 + i] !== {page, 8'(i)}) bad++;
    check({tag, "_read_addrs"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (spram[i] !== mem_val({page, 8'(i)})) bad++;
    check({tag, "_spram"}, 32'(bad), 32'd0);
    if (page != 8'h00) check({tag, "_no_zero_access"}, 32'(zero_hit - z0), 32'd0);
  endtask

  initial begin
    int w0, r0, d0, bad, n;
    logic [7:0] rp;
    rst = 1'b1;
    bus.cpu_addr_in  = 16'h0000;
    bus.cpu_data_in  = 8'h00;
    bus.cpu_write_en = 1'b0;
    bus.cpu_read_en  = 1'b0;
    bus.mem_busy     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(bus.cpu_stall), 32'd0);
    check("rst_active", 32'(bus.dma_active), 32'd0);
    check("rst_done", 32'(bus.dma_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Passthrough write then read back
    bus.cpu_addr_in  = 16'h0010;
    bus.cpu_data_in  = 8'h5A;
    bus.cpu_write_en = 1'b1;
    #1;
    check("pt_addr", 32'(bus.mem_addr), 32'h0010);
    check("pt_data", 32'(bus.mem_data_out), 32'h5A);
    check("pt_we", 32'(bus.mem_write_en), 32'd1);
    check("pt_stall", 32'(bus.cpu_stall), 32'd0);
    @(negedge clk);
    bus.cpu_write_en = 1'b0;
    bus.cpu_read_en  = 1'b1;
    #1 check("pt_re", 32'(bus.mem_read_en), 32'd1);
    @(negedge clk);
    bus.cpu_read_en = 1'b0;
    check("pt_rdata", 32'(bus.cpu_data_out), 32'h5A);
    bus.cpu_addr_in = 16'h4014;
    bus.cpu_read_en = 1'b1;
    #1;
    check("rd4014_re", 32'(bus.mem_read_en), 32'd1);
    check("rd4014_addr", 32'(bus.mem_addr), 32'h4014);
    @(negedge clk);
    bus.cpu_read_en = 1'b0;
    check("rd4014_no_dma", 32'(bus.dma_active), 32'd0);

    run_dma("even", 8'h02, 1'b0, 0);
    run_dma("odd", 8'h02, 1'b1, 0);
    run_dma("busy", 8'h02, 1'b0, 1);

    // Ignored re-trigger, then reset abort mid-transfer
    cpu_write(16'h2003, 8'h00);
    w0 = wr_log.size(); r0 = rd_log.size(); d0 = done_cnt;
    cpu_write(16'h4014, 8'h02);
    for (int c = 0; c < 200 && (wr_log.size() - w0) < 'h10; c++) @(negedge clk);
    bus.cpu_addr_in  = 16'h4014;
    bus.cpu_data_in  = 8'h07;
    bus.cpu_write_en = 1'b1;
    #1 check("ign_not_fwd", 32'(bus.mem_write_en && bus.mem_addr == 16'h4014), 32'd0);
    @(negedge clk);
    bus.cpu_write_en = 1'b0;
    for (int c = 0; c < 400 && (wr_log.size() - w0) < 'h80; c++) @(negedge clk);
    check("abort_at_idx80", 32'(wr_log.size() - w0), 32'h80);
    rst = 1'b1;
    @(negedge clk);
    check("abort_stall", 32'(bus.cpu_stall), 32'd0);
    check("abort_active", 32'(bus.dma_active), 32'd0);
    check("abort_we", 32'(bus.mem_write_en), 32'd0);
    check("abort_done", 32'(bus.dma_done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_more_writes", 32'(wr_log.size() - w0), 32'h80);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    n = rd_log.size() - r0;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (rd_log[r0 + i] !== {8'h02, 8'(i)}) bad++;
    check("ign_page_kept", 32'(bad), 32'd0);
    run_dma("restart", 8'h02, 1'b1, 0);

    run_dma("pageff", 8'hFF, 1'b0, 0);

    // Randomized content, page, parity and busy pattern
    for (int t = 0; t < 3; t++) begin
      salt = 8'($urandom);
      rp   = 8'($urandom);
      run_dma("rand", rp, 1'($urandom), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
